// File: rtl/nock_increment_pkg.sv
// nock_increment_pkg: shared memory/execute codes for the Nock increment reducer
package nock_increment_pkg;
  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 64;
  localparam int NOUN_W = 28;
  localparam int TAG_W = 8;
  localparam int TAG_TEL_BIT = 0;
  localparam int TAG_EXEC_BIT = 7;
  localparam logic ATOM = 1'b0;
  localparam logic CELL = 1'b1;
  localparam logic [1:0] ATOM_ATOM = 2'b00;
  localparam logic [1:0] CELL_CELL = 2'b11;
  localparam logic [NOUN_W-1:0] NIL = '0;
  localparam logic [NOUN_W-1:0] NOUN_MAX = '1;
  localparam logic [1:0] GET_CONTENTS = 2'd1;
  localparam logic [1:0] SET_CONTENTS = 2'd2;
  localparam logic [3:0] SYS_FUNC_TRAVERSE = 4'h2;
  localparam logic [3:0] SYS_FUNC_EXECUTE = 4'h3;
  localparam logic [3:0] TRAVERSE_POP = 4'h2;
  localparam logic [3:0] EXECUTE_ERROR = 4'hF;
  localparam logic [7:0] ERR_OK = 8'h00;
  localparam logic [7:0] ERR_NOT_BOXED = 8'h01;
  localparam logic [7:0] ERR_OVERFLOW = 8'h02;
  typedef enum logic [2:0] {
    S_IDLE, S_READ_REQ, S_READ_WAIT, S_CALC, S_WRITE_REQ, S_WRITE_WAIT, S_DONE, S_ERROR
  } state_t;
endpackage

// File: rtl/nock_increment.sv
// nock_increment: reduces [4 b] by incrementing the atom in tel (direct or boxed) and writing it back
module nock_increment
  import nock_increment_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  execute,
  input  logic [MEM_ADDR_W-1:0] module_address,
  input  logic [MEM_DATA_W-1:0] module_data,
  input  logic                  mem_ready,
  input  logic [MEM_DATA_W-1:0] read_data1,
  output logic                  mem_execute,
  output logic [MEM_ADDR_W-1:0] address1,
  output logic [1:0]            mem_func,
  output logic [MEM_DATA_W-1:0] write_data,
  output logic                  module_finished,
  output logic [3:0]            execute_return_sys_func,
  output logic [3:0]            execute_return_state,
  output logic [7:0]            error
);
  state_t state_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [NOUN_W-1:0] operand_q, result_d;
  logic [TAG_W-1:0] md_tag, rd_tag;
  logic [NOUN_W-1:0] md_tel, rd_hed, rd_tel;
  logic rd_boxed_atom;
  logic unused_bits;
  assign md_tag = module_data[MEM_DATA_W-1 -: TAG_W];
  assign md_tel = module_data[NOUN_W-1:0];
  assign rd_tag = read_data1[MEM_DATA_W-1 -: TAG_W];
  assign rd_hed = read_data1[2*NOUN_W-1:NOUN_W];
  assign rd_tel = read_data1[NOUN_W-1:0];
  assign unused_bits = ^{md_tag[TAG_W-1:1], module_data[2*NOUN_W-1:NOUN_W], rd_tag[6:2]};
  // a pointer target is a usable operand only if it is a plain boxed atom: [n ~], not marked for execution
  assign rd_boxed_atom = (rd_tag[1:0] == ATOM_ATOM) && !rd_tag[TAG_EXEC_BIT] && (rd_tel == NIL);
  always_comb result_d = operand_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      operand_q <= '0;
      mem_execute <= 1'b0;
      address1 <= '0;
      mem_func <= '0;
      write_data <= '0;
      module_finished <= 1'b0;
      execute_return_sys_func <= '0;
      execute_return_state <= '0;
      error <= ERR_OK;
    end else begin
      mem_execute <= 1'b0;
      case (state_q)
        S_IDLE: if (execute) begin
          addr_q <= module_address;
          error <= ERR_OK;
          if (md_tag[TAG_TEL_BIT] == ATOM) begin
            operand_q <= md_tel;
            state_q <= S_CALC;
          end else begin
            mem_execute <= 1'b1;
            address1 <= md_tel[MEM_ADDR_W-1:0];
            mem_func <= GET_CONTENTS;
            state_q <= S_READ_REQ;
          end
        end
        S_READ_REQ: begin
          mem_func <= '0;
          state_q <= S_READ_WAIT;
        end
        S_READ_WAIT: if (mem_ready) begin
          if (rd_boxed_atom) begin
            operand_q <= rd_hed;
            state_q <= S_CALC;
          end else begin
            error <= ERR_NOT_BOXED;
            execute_return_sys_func <= SYS_FUNC_EXECUTE;
            execute_return_state <= EXECUTE_ERROR;
            module_finished <= 1'b1;
            state_q <= S_ERROR;
          end
        end
        S_CALC: if (operand_q == NOUN_MAX) begin
          error <= ERR_OVERFLOW;
          execute_return_sys_func <= SYS_FUNC_EXECUTE;
          execute_return_state <= EXECUTE_ERROR;
          module_finished <= 1'b1;
          state_q <= S_ERROR;
        end else begin
          mem_execute <= 1'b1;
          address1 <= addr_q;
          mem_func <= SET_CONTENTS;
          write_data <= {{(TAG_W-2){1'b0}}, ATOM_ATOM, result_d, NIL};
          state_q <= S_WRITE_REQ;
        end
        S_WRITE_REQ: begin
          mem_func <= '0;
          write_data <= '0;
          state_q <= S_WRITE_WAIT;
        end
        S_WRITE_WAIT: if (mem_ready) begin
          execute_return_sys_func <= SYS_FUNC_TRAVERSE;
          execute_return_state <= TRAVERSE_POP;
          module_finished <= 1'b1;
          state_q <= S_DONE;
        end
        default: if (!execute) begin
          module_finished <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nock_increment.sv
// tb_nock_increment: directed and randomized increment operations against a behavioural model
module tb_nock_increment;
  import nock_increment_pkg::*;
  logic clk = 1'b0, rst = 1'b0, execute = 1'b0, mem_ready = 1'b0;
  logic [9:0] module_address = '0;
  logic [63:0] module_data = '0, read_data1 = '0;
  logic mem_execute, module_finished;
  logic [9:0] address1;
  logic [1:0] mem_func;
  logic [63:0] write_data;
  logic [3:0] execute_return_sys_func, execute_return_state;
  logic [7:0] error;
  int checks = 0, errors = 0;

  nock_increment dut (
    .clk(clk), .rst(rst), .execute(execute), .module_address(module_address),
    .module_data(module_data), .mem_ready(mem_ready), .read_data1(read_data1),
    .mem_execute(mem_execute), .address1(address1), .mem_func(mem_func),
    .write_data(write_data), .module_finished(module_finished),
    .execute_return_sys_func(execute_return_sys_func),
    .execute_return_state(execute_return_state), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_execute"}, 64'(mem_execute), 0);
    chk({tag, "_address1"}, 64'(address1), 0);
    chk({tag, "_mem_func"}, 64'(mem_func), 0);
    chk({tag, "_write_data"}, write_data, 0);
    chk({tag, "_finished"}, 64'(module_finished), 0);
    chk({tag, "_ret"}, 64'({execute_return_sys_func, execute_return_state}), 0);
    chk({tag, "_error"}, 64'(error), 0);
  endtask

  // Reference: decide the operand from the node, then increment with unbounded arithmetic
  function automatic void model(input logic [63:0] node, input logic [63:0] resp,
                                output logic [7:0] err, output logic [27:0] res, output bit rd);
    longint op, sum;
    err = 8'h00;
    res = '0;
    rd = node[56];
    op = 0;
    if (!rd) op = longint'(node[27:0]);
    else if (resp[57:56] == 2'b00 && !resp[63] && resp[27:0] == 28'h0) op = longint'(resp[55:28]);
    else err = 8'h01;
    sum = op + 1;
    if (err == 8'h00) begin
      if (sum >= (longint'(1) << 28)) err = 8'h02;
      else res = sum[27:0];
    end
  endfunction

  task automatic run_op(input logic [63:0] node, input logic [9:0] addr, input logic [63:0] resp,
                        input int delay, input bit drop);
    logic [7:0] e_err;
    logic [27:0] e_res;
    bit e_read, done, prev;
    int reads, writes, wait_cnt, lat;
    model(node, resp, e_err, e_res, e_read);
    done = 0; prev = 0; reads = 0; writes = 0; wait_cnt = 0; lat = 0;
    execute = 1'b1;
    module_address = addr;
    module_data = node;
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      lat++;
      mem_ready = 1'b0;
      if (drop && c == 1) execute = 1'b0;
      if (module_finished) done = 1;
      else if (mem_execute) begin
        chk("strobe_back_to_back", 64'(prev), 0);
        chk("one_outstanding", 64'(wait_cnt), 0);
        if (mem_func == GET_CONTENTS) begin
          reads++;
          chk("get_addr", 64'(address1), 64'(node[9:0]));
        end else begin
          writes++;
          chk("set_func", 64'(mem_func), 64'(SET_CONTENTS));
          chk("set_addr", 64'(address1), 64'(addr));
          chk("set_data", write_data, {8'h00, e_res, 28'h0});
        end
        wait_cnt = delay + 1;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          mem_ready = 1'b1;
          read_data1 = resp;
        end
      end
      prev = mem_execute;
    end
    chk("finished", 64'(done), 1);
    if (delay == 0 && !e_read && e_err == 8'h00) chk("latency", 64'(lat), 4);
    chk("reads", 64'(reads), 64'(e_read));
    chk("writes", 64'(writes), 64'(e_err == 8'h00));
    chk("error", 64'(error), 64'(e_err));
    chk("ret", 64'({execute_return_sys_func, execute_return_state}), e_err == 8'h00 ? 64'h22 : 64'h3F);
    if (!drop) begin
      tick();
      chk("finished_held", 64'(module_finished), 1);
      chk("ret_held", 64'({execute_return_sys_func, execute_return_state}), e_err == 8'h00 ? 64'h22 : 64'h3F);
    end
    execute = 1'b0;
    tick();
    chk("finished_clear", 64'(module_finished), 0);
    chk("error_hold", 64'(error), 64'(e_err));
  endtask

  initial begin
    logic [63:0] node, resp;
    logic [27:0] v;
    bit seen;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("idle_ready_ignored_strobe", 64'(mem_execute), 0);
    chk("idle_ready_ignored_fin", 64'(module_finished), 0);
    run_op({8'h00, 28'h0, 28'd5}, 10'h011, 64'h0, 0, 0);
    run_op({8'h01, 28'h0, 28'h3}, 10'h022, {8'h00, 28'd41, 28'h0}, 0, 0);
    run_op({8'h01, 28'h0, 28'h4}, 10'h033, {8'h03, 28'd41, 28'd9}, 0, 0);
    run_op({8'h00, 28'h0, 28'hFFFFFFF}, 10'h044, 64'h0, 0, 0);
    run_op({8'h01, 28'h0, 28'h5}, 10'h055, {8'h00, 28'hFFFFFFE, 28'h0}, 5, 0);
    run_op({8'h01, 28'h0, 28'h6}, 10'h066, {8'h80, 28'd3, 28'h0}, 2, 1);
    run_op({8'h00, 28'h0, 28'd77}, 10'h077, 64'h0, 1, 1);
    // reset while a write is outstanding, then a late mem_ready
    execute = 1'b1;
    module_address = 10'h3AA;
    module_data = {8'h00, 28'h0, 28'd7};
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = mem_execute;
    end
    chk("wr_strobe_seen", 64'(seen), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    execute = 1'b0;
    chk_reset_outputs("rst_write_wait");
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    chk("late_ready_fin", 64'(module_finished), 0);
    chk("late_ready_strobe", 64'(mem_execute), 0);
    chk("late_ready_ret", 64'({execute_return_sys_func, execute_return_state}), 0);
    for (int i = 0; i < 40; i++) begin
      v = 28'($urandom);
      if ($urandom_range(0, 3) == 0) v = 28'hFFFFFFF - 28'($urandom_range(0, 1));
      node = {8'($urandom), 28'($urandom), v};
      v = 28'($urandom);
      if ($urandom_range(0, 2) == 0) v = 28'hFFFFFFF - 28'($urandom_range(0, 1));
      resp = $urandom_range(0, 1) ? {1'b0, 5'($urandom), 2'b00, v, 28'h0}
                                  : {32'($urandom), 32'($urandom)};
      run_op(node, 10'($urandom), resp, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nock_increment.md
NOCK_INCREMENT -- requirements
Module: nock_increment

Interface
REQ-001 One clock; reset is synchronous and active-high: ports named clk and rst, all state sampled on posedge clk, rst=1 forces reset.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 execute  input  1  level; high while the traversal mux selects MUX_INCR.
REQ-005 module_address  input  memory_addr_width (10)  address of the [4 b] node being reduced.
REQ-006 module_data  input  memory_data_width (64)  node word {tag[7:0], hed[27:0], tel[27:0]}.
REQ-007 mem_ready  input  1  memory request complete.
REQ-008 read_data1  input  64  memory read data, valid with mem_ready.
REQ-009 mem_execute  output  1  memory request strobe.
REQ-010 address1  output  10  memory address.
REQ-011 mem_func  output  2  GET_CONTENTS or SET_CONTENTS.
REQ-012 write_data  output  64  memory write data.
REQ-013 module_finished  output  1  operation complete.
REQ-014 execute_return_sys_func  output  4  traversal function to resume in.
REQ-015 execute_return_state  output  4  traversal state to resume in.
REQ-016 error  output  8  0 = ok; 8'h01 = operand is a non-boxed cell; 8'h02 = 28-bit overflow.

Function
REQ-017 States: IDLE, READ_REQ, READ_WAIT, CALC, WRITE_REQ, WRITE_WAIT, DONE, ERROR.
REQ-018 IDLE -> on execute=1, latch module_address and module_data; if tag[0] marks tel as atom, operand = tel and go to CALC; otherwise go to READ_REQ.
REQ-019 READ_REQ: mem_execute=1, address1=tel, mem_func=GET_CONTENTS for exactly one cycle; next state READ_WAIT.
REQ-020 READ_WAIT: mem_execute=0, mem_func=0; on mem_ready, if read_data1 tag[1:0]=ATOM_ATOM, execute bit tag[7]=0 and tel=NIL, operand = read_data1 hed and go to CALC; otherwise error=8'h01 and go to ERROR.
REQ-021 CALC: operand = 28'hFFFFFFF sets error=8'h02 and goes to ERROR; otherwise result = operand+1 (28-bit, no wrap) and go to WRITE_REQ.
REQ-022 WRITE_REQ: one-cycle strobe, address1=latched module_address, mem_func=SET_CONTENTS, write_data={tag ATOM_ATOM with bits[7:2]=0, hed=result, tel=NIL}; next state WRITE_WAIT.
REQ-023 WRITE_WAIT: strobe and data low; on mem_ready go to DONE with return func 4'h2 (TRAVERSE) and state 4'h2 (POP).
REQ-024 ERROR: return func 4'h3 (EXECUTE), state 4'hF (EXECUTE_ERROR); then behave as DONE.
REQ-025 DONE/ERROR: module_finished=1 and return fields stable while execute=1; on execute=0 return to IDLE with module_finished=0; error holds its value until the next start.
REQ-026 mem_execute is never high for two consecutive cycles; only one memory request is outstanding at a time.
REQ-027 execute dropping mid-operation does not abort; the block completes and waits in DONE/ERROR.
REQ-028 mem_ready arriving in any state other than READ_WAIT or WRITE_WAIT is ignored.
REQ-029 Latency (zero-wait memory, direct atom): execute high to module_finished high = 4 cycles.

Reset
REQ-030 rst=1 sets state=IDLE, mem_execute=0, address1=0, mem_func=0, write_data=0, module_finished=0, error=0, and both return fields = 0, all on the next clock edge.
REQ-031 rst takes priority over every state, including an outstanding memory request; a late mem_ready is ignored.

Structure
REQ-032 Widths, tag bit positions, ATOM/CELL codes, NIL, GET_CONTENTS/SET_CONTENTS, sys_func/state return codes and error codes are taken from the shared memory_unit.vh/execute.vh headers, not redefined locally.
REQ-033 Single module with no sub-modules; error codes are added to execute.vh.

Verification
REQ-034 Node tel=atom 5 -> one SET_CONTENTS to module_address, hed=6, tel=NIL; finished with return 2/2 and error 0.
REQ-035 tel=pointer to boxed atom 41 -> one GET then one SET; hed=42.
REQ-036 tel=pointer to word with tag CELL_CELL -> no SET issued; error=8'h01, return 3/F.
REQ-037 tel=28'hFFFFFFF -> error=8'h02, no memory write.
REQ-038 rst asserted during WRITE_WAIT -> all outputs reach reset values next cycle; the following mem_ready has no effect.
REQ-039 mem_ready delayed 5 cycles -> mem_execute stays 0 throughout the wait; finished held until execute=0.
